// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
// apu_pkg : shared length-counter table and waveform mode encoding
// Rev 1.0
// ============================================================================
package apu_pkg;

    typedef enum logic [1:0] {
        MODE_TRI  = 2'd0,
        MODE_SAW  = 2'd1,
        MODE_SQR  = 2'd2,
        MODE_HOLD = 2'd3
    } mode_e;

    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        return LEN_TABLE[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_linear_counter.sv
`default_nettype none
// ============================================================================
// apu_linear_counter : quarter-frame linear counter with reload flag and gate
// Rev 1.0
// ============================================================================
module apu_linear_counter #(
    parameter int LIN_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             qframe_i,
    input  logic             reload_set_i,
    input  logic             ctrl_i,
    input  logic [LIN_W-1:0] reload_val_i,
    output logic             gate_o
);

    logic             flag_q, flag_d;
    logic [LIN_W-1:0] cnt_q, cnt_d;

    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (reload_set_i) begin
            flag_d = 1'b1;
        end else if (qframe_i && !ctrl_i) begin
            flag_d = 1'b0;
        end
        // A reg3 write landing on the same quarter frame still counts as a pending reload.
        if (qframe_i) begin
            if (flag_q || reload_set_i) begin
                cnt_d = reload_val_i;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign gate_o = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/apu_wave_channel.sv
`default_nettype none
// ============================================================================
// apu_wave_channel : timer-driven wave sequencer with linear/length gating
// Rev 1.0
// ============================================================================
module apu_wave_channel
    import apu_pkg::*;
#(
    parameter int OUT_W   = 4,
    parameter int TIMER_W = 11,
    parameter int LIN_W   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_ce,
    input  logic             qframe,
    input  logic             hframe,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [7:0]       wdata,
    input  logic             en,
    output logic             act,
    output logic [OUT_W-1:0] out
);

    localparam int SEQ_W = OUT_W + 1;

    logic [7:0]         regs_q [4];
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [7:0]         len_q, len_d;

    logic               wr3;
    logic [TIMER_W-1:0] period;
    logic [TIMER_W-1:0] new_period;
    logic               lin_gate;
    logic               step;
    mode_e              mode;
    logic [OUT_W-1:0]   wave;
    logic               unused_bits;

    assign wr3        = we && (addr == 2'd3);
    assign period     = TIMER_W'({regs_q[3][2:0], regs_q[2]});
    assign new_period = TIMER_W'({wdata[2:0], regs_q[2]});
    assign mode       = mode_e'(regs_q[1][1:0]);
    assign unused_bits = ^regs_q[1][7:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
        end else if (we) begin
            regs_q[addr] <= wdata;
        end
    end

    apu_linear_counter #(
        .LIN_W (LIN_W)
    ) u_lin (
        .clk          (clk),
        .reset        (reset),
        .qframe_i     (qframe),
        .reload_set_i (wr3),
        .ctrl_i       (regs_q[0][7]),
        .reload_val_i (LIN_W'(regs_q[0][6:0])),
        .gate_o       (lin_gate)
    );

    // Periods 0 and 1 are ultrasonic: the sequencer is frozen rather than aliased.
    assign step = cpu_ce && (timer_q == '0) && lin_gate && (len_q != 8'd0)
                  && (period >= TIMER_W'(2)) && (mode != MODE_HOLD);

    always_comb begin
        timer_d = timer_q;
        if (!en) begin
            timer_d = '0;
        end else if (wr3) begin
            timer_d = new_period;
        end else if (cpu_ce) begin
            timer_d = (timer_q == '0) ? period : timer_q - 1'b1;
        end

        seq_d = step ? seq_q + 1'b1 : seq_q;

        len_d = len_q;
        if (!en) begin
            len_d = 8'd0;
        end else if (wr3) begin
            len_d = len_lookup(wdata[7:3]);
        end else if (hframe && !regs_q[0][7] && (len_q != 8'd0)) begin
            len_d = len_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            seq_q   <= '0;
            len_q   <= 8'd0;
        end else begin
            timer_q <= timer_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        case (mode)
            MODE_SAW: wave = seq_q[SEQ_W-1:1];
            MODE_SQR: wave = {OUT_W{seq_q[SEQ_W-1]}};
            default:  wave = {OUT_W{seq_q[SEQ_W-1]}} ^ seq_q[OUT_W-1:0];
        endcase
    end

    assign out = en ? wave : '0;
    assign act = (len_q != 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_apu_wave_channel.sv
`default_nettype none
// ============================================================================
// tb_apu_wave_channel : directed and random checks against a behavioural model
// Rev 1.0
// ============================================================================
module tb_apu_wave_channel;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_ce = 1'b0, qframe = 1'b0, hframe = 1'b0, we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'd0;
    logic       en = 1'b0;
    logic       act;
    logic [3:0] out;

    int n_asserts = 0;
    int n_fails   = 0;

    // Behavioural model state, plain integers.
    int m_regs [4];
    int m_timer, m_seq, m_lin, m_flag, m_len;

    int len_tab [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                         12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    apu_wave_channel dut (
        .clk    (clk),
        .reset  (reset),
        .cpu_ce (cpu_ce),
        .qframe (qframe),
        .hframe (hframe),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .en     (en),
        .act    (act),
        .out    (out)
    );

    always #5 clk = ~clk;

    function automatic int wave_of(input int mode, input int s);
        case (mode)
            1:       return s / 2;
            2:       return (s >= 16) ? 15 : 0;
            default: return (s < 16) ? s : 31 - s;
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        int per, ctrl, wr3, stp, mode;
        int n_timer, n_seq, n_lin, n_flag, n_len;
        n_timer = m_timer; n_seq = m_seq; n_lin = m_lin; n_flag = m_flag; n_len = m_len;
        per  = (m_regs[3] % 8) * 256 + m_regs[2];
        ctrl = m_regs[0] / 128;
        mode = m_regs[1] % 4;
        wr3  = (we && addr == 2'd3) ? 1 : 0;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            n_timer = 0; n_seq = 0; n_lin = 0; n_flag = 0; n_len = 0;
        end else begin
            stp = (cpu_ce && m_timer == 0 && m_lin != 0 && m_len != 0 && per >= 2 && mode != 3) ? 1 : 0;
            n_seq = (m_seq + stp) % 32;
            if (!en)          n_timer = 0;
            else if (wr3)     n_timer = (wdata % 8) * 256 + m_regs[2];
            else if (cpu_ce)  n_timer = (m_timer == 0) ? per : m_timer - 1;
            if (qframe) begin
                if (m_flag || wr3) n_lin = m_regs[0] % 128;
                else if (m_lin > 0) n_lin = m_lin - 1;
            end
            if (wr3) n_flag = 1;
            else if (qframe && ctrl == 0) n_flag = 0;
            if (!en)          n_len = 0;
            else if (wr3)     n_len = len_tab[wdata / 8];
            else if (hframe && ctrl == 0 && m_len > 0) n_len = m_len - 1;
            if (we) m_regs[addr] = wdata;
        end
        @(posedge clk);
        #1;
        m_timer = n_timer; m_seq = n_seq; m_lin = n_lin; m_flag = n_flag; m_len = n_len;
        chk("out", int'(out), en ? wave_of(m_regs[1] % 4, m_seq) : 0);
        chk("act", int'(act), (m_len != 0) ? 1 : 0);
    endtask

    task automatic idle();
        reset = 1'b0; cpu_ce = 1'b0; qframe = 1'b0; hframe = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        idle();
        we = 1'b1; addr = 2'(a); wdata = 8'(d);
        tick();
        we = 1'b0;
    endtask

    task automatic run_ce(input int n);
        idle();
        cpu_ce = 1'b1;
        for (int i = 0; i < n; i++) tick();
        cpu_ce = 1'b0;
    endtask

    task automatic qf();
        idle(); qframe = 1'b1; tick(); qframe = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_timer = 0; m_seq = 0; m_lin = 0; m_flag = 0; m_len = 0;

        // Reset state
        reset = 1'b1; tick(); tick();
        chk("reset_out", int'(out), 0);
        chk("reset_act", int'(act), 0);

        // Triangle: period 2 -> one step every 3rd cpu_ce
        idle(); en = 1'b1;
        wr(0, 8'h81); wr(2, 8'h02); wr(3, 8'h08); qf();
        idle(); cpu_ce = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (i == 44) chk("tri_peak", int'(out), 15);
            if (i == 62) chk("tri_fall", int'(out), 10);
        end

        // Sawtooth then square
        wr(1, 1); run_ce(60);
        wr(1, 2); run_ce(110);
        wr(1, 3); run_ce(12);
        wr(1, 0);

        // Linear counter expiry with ctrl=0
        wr(0, 8'h03); wr(3, 8'h08);
        idle(); cpu_ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            qframe = 1'b1; tick(); qframe = 1'b0; tick(); tick();
        end
        run_ce(20);

        // Length counter expiry and reload-beats-hframe
        wr(0, 8'h00); wr(3, 8'h18);
        chk("len_load_act", int'(act), 1);
        idle(); hframe = 1'b1; tick();
        chk("len_h1_act", int'(act), 1);
        tick();
        chk("len_h2_act", int'(act), 0);
        idle(); hframe = 1'b1; we = 1'b1; addr = 2'd3; wdata = 8'h18; tick();
        chk("len_reload_act", int'(act), 1);
        idle(); hframe = 1'b1; tick();
        chk("len_after_reload", int'(act), 1);

        // Ultrasonic mute, then enable drop, then mid-step reset
        wr(0, 8'h81); wr(2, 8'h01); wr(3, 8'h08); qf(); run_ce(20);
        wr(2, 8'h02); wr(3, 8'h08); qf(); run_ce(17);
        idle(); en = 1'b0; tick();
        chk("en0_out", int'(out), 0);
        chk("en0_act", int'(act), 0);
        idle(); en = 1'b1; wr(3, 8'h08); qf(); run_ce(8);
        idle(); cpu_ce = 1'b1; reset = 1'b1; tick();
        chk("midreset_act", int'(act), 0);
        chk("midreset_out", int'(out), 0);

        // Randomized traffic
        idle();
        for (int i = 0; i < 4000; i++) begin
            reset  = ($urandom_range(0, 499) == 0);
            cpu_ce = $urandom_range(0, 1);
            qframe = ($urandom_range(0, 15) == 0);
            hframe = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) en = ~en;
            we   = ($urandom_range(0, 7) == 0);
            addr = 2'($urandom_range(0, 3));
            case (addr)
                2'd2:    wdata = 8'($urandom_range(0, 5));
                2'd3:    wdata = 8'({5'($urandom), 3'b000});
                default: wdata = 8'($urandom);
            endcase
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
